// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control and display bundle for led_pattern_gen.
//   en    : run enable (prescaler counts while high)
//   div   : step period in clk cycles (0 behaves as 1)
//   mode  : 0 binary, 1 rotate, 2 bounce, 3 Gray
//   dir   : 0 up/left, 1 down/right (ignored in bounce)
//   step  : manual advance, honoured only while en=0
//   led   : registered pattern output
//   tick  : one-cycle pulse on each advance
//   wrap  : one-cycle pulse when an advance completes a full pattern cycle
// master drives the controls and observes the display; slave is the generator.
interface led_pattern_gen_if #(
  parameter int LED_W = 8,
  parameter int DIV_W = 32
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic [1:0]       mode;
  logic             dir;
  logic             step;
  logic [LED_W-1:0] led;
  logic             tick;
  logic             wrap;

  modport master (
    output en, div, mode, dir, step,
    input  led, tick, wrap
  );

  modport slave (
    input  en, div, mode, dir, step,
    output led, tick, wrap
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern generator for board bring-up and status display.
// A programmable prescaler produces step ticks; each tick advances the pattern
// in binary-count, rotating one-hot, bounce (scanner) or Gray-count mode.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : led_pattern_gen_if.slave (en, div, mode, dir, step in; led, tick, wrap out)
module led_pattern_gen #(
  parameter int LED_W = 8,
  parameter int DIV_W = 32
) (
  input logic              clk,
  input logic              rst,
  led_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_ROT  = 2'd1,
    MODE_BNC  = 2'd2,
    MODE_GRAY = 2'd3
  } mode_t;

  typedef enum logic {
    BDIR_UP   = 1'b0,
    BDIR_DOWN = 1'b1
  } bdir_t;

  localparam logic [LED_W-1:0] ONE = LED_W'(1);

  // Count modes start from zero; one-hot modes start with the LSB lit.
  function automatic logic [LED_W-1:0] seed(mode_t m);
    return (m == MODE_ROT || m == MODE_BNC) ? ONE : '0;
  endfunction

  // Gray mode shows the Gray code of the binary counter held in pat.
  function automatic logic [LED_W-1:0] display(mode_t m, logic [LED_W-1:0] p);
    return (m == MODE_GRAY) ? (p ^ (p >> 1)) : p;
  endfunction

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [LED_W-1:0] led_q, led_d;
  bdir_t            bdir_q, bdir_d;
  mode_t            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  mode_t            mode_in;
  logic [DIV_W-1:0] div_eff;
  logic             at_term;
  logic             advance;

  assign mode_in = mode_t'(bus.mode);
  assign div_eff = (bus.div == '0) ? DIV_W'(1) : bus.div;
  assign at_term = (cnt_q >= div_eff - DIV_W'(1));

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    bdir_d  = bdir_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    advance = 1'b0;

    if (mode_in != mode_q) begin
      // Mode switch restarts the pattern and the prescaler; en/step ignored.
      mode_d = mode_in;
      pat_d  = seed(mode_in);
      bdir_d = BDIR_UP;
      cnt_d  = '0;
    end else begin
      if (bus.en) begin
        if (at_term) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end else begin
        advance = bus.step;
      end

      if (advance) begin
        tick_d = 1'b1;
        case (mode_q)
          MODE_ROT: begin
            pat_d  = bus.dir ? {pat_q[0], pat_q[LED_W-1:1]}
                             : {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            wrap_d = (pat_d == ONE);
          end
          MODE_BNC: begin
            if (bdir_q == BDIR_UP) begin
              pat_d = pat_q << 1;
              if (pat_d[LED_W-1]) bdir_d = BDIR_DOWN;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_d[0]) begin
                bdir_d = BDIR_UP;
                wrap_d = 1'b1;
              end
            end
          end
          default: begin  // MODE_BIN and MODE_GRAY share the binary counter
            if (bus.dir) begin
              pat_d  = pat_q - ONE;
              wrap_d = (pat_q == '0);
            end else begin
              pat_d  = pat_q + ONE;
              wrap_d = (pat_q == '1);
            end
          end
        endcase
      end
    end

    led_d = display(mode_d, pat_d);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= mode_in;
      pat_q  <= seed(mode_in);
      bdir_q <= BDIR_UP;
      led_q  <= display(mode_in, seed(mode_in));
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      bdir_q <= bdir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen
// (LED_W=8, DIV_W=32). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so each cyc() call covers one edge.
module tb_led_pattern_gen;

  localparam int LED_W = 8;
  localparam int DIV_W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  led_pattern_gen_if #(.LED_W(LED_W), .DIV_W(DIV_W)) bus ();

  led_pattern_gen #(.LED_W(LED_W), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_ctl(input logic [1:0] m, input logic d, input int dv, input logic e);
    bus.mode = m;
    bus.dir  = d;
    bus.div  = DIV_W'(dv);
    bus.en   = e;
    bus.step = 1'b0;
  endtask

  // Reset values, then div=4: advances at edges 4, 8, 12 only.
  task automatic test_reset();
    logic [7:0] exp_led;
    logic       exp_tick;
    set_ctl(2'd0, 1'b0, 4, 1'b1);
    do_reset();
    total++; if (bus.led !== 8'd0) begin bad++; $display("FAIL reset_led: got %0d want 0", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", bus.wrap); end
    for (int e = 1; e <= 12; e++) begin
      cyc();
      exp_led  = 8'(e / 4);
      exp_tick = (e % 4 == 0);
      total++; if (bus.led !== exp_led) begin bad++; $display("FAIL div4_led e=%0d: got %0d want %0d", e, bus.led, exp_led); end
      total++; if (bus.tick !== exp_tick) begin bad++; $display("FAIL div4_tick e=%0d: got %b want %b", e, bus.tick, exp_tick); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL div4_wrap e=%0d: got %b want 0", e, bus.wrap); end
    end
  endtask

  // Binary count, div=1: full 256-step cycle, then count down through 0.
  task automatic test_binary();
    int nwrap;
    set_ctl(2'd0, 1'b0, 1, 1'b1);
    do_reset();
    nwrap = 0;
    for (int k = 1; k <= 256; k++) begin
      cyc();
      if (bus.wrap === 1'b1) nwrap++;
      total++; if (bus.led !== 8'(k)) begin bad++; $display("FAIL bin_led k=%0d: got %0d want %0d", k, bus.led, 8'(k)); end
    end
    total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL bin_wrap_up: got %b want 1", bus.wrap); end
    total++; if (nwrap != 1) begin bad++; $display("FAIL bin_wrap_count: got %0d want 1", nwrap); end
    bus.dir = 1'b1;
    cyc();
    total++; if (bus.led !== 8'd255) begin bad++; $display("FAIL bin_down_led: got %0d want 255", bus.led); end
    total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL bin_down_wrap: got %b want 1", bus.wrap); end
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL bin_down_tick: got %b want 1", bus.tick); end
    bus.en = 1'b0;
  endtask

  // Bounce with dir=1 (must be ignored): 1,2,..,128,64,..,1 with wrap every 14.
  task automatic test_bounce();
    int         p;
    int         pos;
    logic [7:0] exp_led;
    logic       exp_wrap;
    set_ctl(2'd2, 1'b1, 1, 1'b1);
    do_reset();
    total++; if (bus.led !== 8'd1) begin bad++; $display("FAIL bnc_seed: got %0d want 1", bus.led); end
    for (int k = 1; k <= 29; k++) begin
      cyc();
      p        = k % 14;
      pos      = (p <= 7) ? p : 14 - p;
      exp_led  = 8'd1 << pos;
      exp_wrap = (p == 0);
      total++; if (bus.led !== exp_led) begin bad++; $display("FAIL bnc_led k=%0d: got %0h want %0h", k, bus.led, exp_led); end
      total++; if (bus.wrap !== exp_wrap) begin bad++; $display("FAIL bnc_wrap k=%0d: got %b want %b", k, bus.wrap, exp_wrap); end
    end
  endtask

  // Gray with div=0 (every edge), then switch to rotate right.
  task automatic test_gray_rotate();
    logic [7:0] gray_tbl [9];
    logic [7:0] exp_led;
    logic       exp_wrap;
    gray_tbl = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4, 8'd12};
    set_ctl(2'd3, 1'b0, 0, 1'b1);
    do_reset();
    total++; if (bus.led !== gray_tbl[0]) begin bad++; $display("FAIL gray_seed: got %0d want 0", bus.led); end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++; if (bus.led !== gray_tbl[k]) begin bad++; $display("FAIL gray_led k=%0d: got %0d want %0d", k, bus.led, gray_tbl[k]); end
      total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL gray_tick k=%0d: got %b want 1", k, bus.tick); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL gray_wrap k=%0d: got %b want 0", k, bus.wrap); end
    end
    bus.mode = 2'd1;
    bus.dir  = 1'b1;
    cyc();
    total++; if (bus.led !== 8'd1) begin bad++; $display("FAIL rot_seed: got %0h want 1", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL rot_seed_tick: got %b want 0", bus.tick); end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      exp_led  = 8'd1 << ((8 - (k % 8)) % 8);
      exp_wrap = (k % 8 == 0);
      total++; if (bus.led !== exp_led) begin bad++; $display("FAIL rot_led k=%0d: got %0h want %0h", k, bus.led, exp_led); end
      total++; if (bus.wrap !== exp_wrap) begin bad++; $display("FAIL rot_wrap k=%0d: got %b want %b", k, bus.wrap, exp_wrap); end
    end
  endtask

  // Lower div mid-count, then change mode mid-count.
  task automatic test_div_change();
    logic       exp_tick;
    logic [7:0] exp_led;
    set_ctl(2'd0, 1'b0, 10, 1'b1);
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      cyc();
      total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL div10_tick k=%0d: got %b want 0", k, bus.tick); end
    end
    bus.div = DIV_W'(3);
    cyc();
    total++; if (bus.led !== 8'd1) begin bad++; $display("FAIL divlow_led: got %0d want 1", bus.led); end
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL divlow_tick: got %b want 1", bus.tick); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      exp_tick = (k % 3 == 0);
      exp_led  = 8'(1 + k / 3);
      total++; if (bus.tick !== exp_tick) begin bad++; $display("FAIL div3_tick k=%0d: got %b want %b", k, bus.tick, exp_tick); end
      total++; if (bus.led !== exp_led) begin bad++; $display("FAIL div3_led k=%0d: got %0d want %0d", k, bus.led, exp_led); end
    end
    bus.div = DIV_W'(10);
    for (int k = 1; k <= 5; k++) cyc();
    bus.mode = 2'd1;
    cyc();
    total++; if (bus.led !== 8'd1) begin bad++; $display("FAIL mchg_led: got %0d want 1", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL mchg_tick: got %b want 0", bus.tick); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL mchg_wrap: got %b want 0", bus.wrap); end
    for (int k = 1; k <= 9; k++) begin
      cyc();
      total++; if (bus.tick !== 1'b0 || bus.led !== 8'd1) begin bad++; $display("FAIL mchg_hold k=%0d: got led=%0d tick=%b want led=1 tick=0", k, bus.led, bus.tick); end
    end
    cyc();
    total++; if (bus.led !== 8'd2) begin bad++; $display("FAIL mchg_adv_led: got %0d want 2", bus.led); end
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL mchg_adv_tick: got %b want 1", bus.tick); end
  endtask

  // Manual step with en=0; prescaler count must survive the pause.
  task automatic test_step();
    int ntick;
    set_ctl(2'd0, 1'b0, 5, 1'b1);
    do_reset();
    cyc();
    cyc();
    bus.en = 1'b0;
    ntick  = 0;
    bus.step = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (bus.tick === 1'b1) ntick++;
      total++; if (bus.led !== 8'(k)) begin bad++; $display("FAIL step_led k=%0d: got %0d want %0d", k, bus.led, k); end
    end
    bus.step = 1'b0;
    cyc();
    if (bus.tick === 1'b1) ntick++;
    total++; if (bus.led !== 8'd3) begin bad++; $display("FAIL step_gap_led: got %0d want 3", bus.led); end
    bus.step = 1'b1;
    cyc();
    if (bus.tick === 1'b1) ntick++;
    bus.step = 1'b0;
    total++; if (bus.led !== 8'd4) begin bad++; $display("FAIL step_pulse_led: got %0d want 4", bus.led); end
    cyc();
    if (bus.tick === 1'b1) ntick++;
    cyc();
    if (bus.tick === 1'b1) ntick++;
    total++; if (ntick != 4) begin bad++; $display("FAIL step_ticks: got %0d want 4", ntick); end
    total++; if (bus.led !== 8'd4) begin bad++; $display("FAIL step_hold_led: got %0d want 4", bus.led); end
    bus.en = 1'b1;
    cyc();
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL resume_tick1: got %b want 0", bus.tick); end
    cyc();
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL resume_tick2: got %b want 0", bus.tick); end
    cyc();
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL resume_tick3: got %b want 1", bus.tick); end
    total++; if (bus.led !== 8'd5) begin bad++; $display("FAIL resume_led: got %0d want 5", bus.led); end
  endtask

  // Reset on the edge that would otherwise complete the bounce cycle.
  task automatic test_reset_mid();
    set_ctl(2'd2, 1'b0, 1, 1'b1);
    do_reset();
    for (int k = 1; k <= 13; k++) cyc();
    total++; if (bus.led !== 8'd2) begin bad++; $display("FAIL rmid_pre_led: got %0h want 2", bus.led); end
    rst = 1'b1;
    cyc();
    total++; if (bus.led !== 8'd1) begin bad++; $display("FAIL rmid_led: got %0h want 1", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL rmid_tick: got %b want 0", bus.tick); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL rmid_wrap: got %b want 0", bus.wrap); end
    rst = 1'b0;
    cyc();
    total++; if (bus.led !== 8'd2) begin bad++; $display("FAIL rmid_post_led: got %0h want 2", bus.led); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL rmid_post_wrap: got %b want 0", bus.wrap); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_ctl(2'd0, 1'b0, 4, 1'b0);
    test_reset();
    test_binary();
    test_bounce();
    test_gray_rotate();
    test_div_change();
    test_step();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for board bring-up and status display. A runtime-programmable prescaler produces step ticks. Each tick advances a pattern in one of four modes: binary count, rotating one-hot, bounce (scanner) and Gray count. Direction control, manual single-step and a cycle-complete pulse are provided. The block drives board LED pins directly from the top level.

## Interface
- LED_W, default 8: LED count and pattern width; minimum 2.
- DIV_W, default 32: prescaler and `div` width.
- clk  in  1: clock.
- rst  in  1: reset, synchronous, active-high.
- en  in  1: run enable; 1 means the prescaler counts.
- div  in  DIV_W: step period in clk cycles; 0 is treated as 1.
- mode  in  2: 0 binary, 1 rotate, 2 bounce, 3 Gray.
- dir  in  1: 0 up/left (toward MSB), 1 down/right; ignored in bounce mode.
- step  in  1: manual advance, sampled only while en=0.
- led  out  LED_W: registered pattern output.
- tick  out  1: registered one-cycle pulse, 1 on each cycle in which the pattern advanced.
- wrap  out  1: registered one-cycle pulse, 1 when the advance completes a full pattern cycle.

## Operation
- State: prescaler `cnt` (DIV_W), pattern register `pat` (LED_W), bounce direction `bdir`, registered mode `mode_q`.
- Seeds: modes 0/3 use pat=0; modes 1/2 use pat=1 (bit 0). bdir seed=up.
- Display: led=pat in modes 0/1/2; led=pat^(pat>>1) in mode 3. led is a register updated on the same edge as pat.
- Reset: cnt=0, tick=0, wrap=0, mode_q=mode, pat=seed(mode), bdir=up, led=display(seed).
- Priority per edge: rst > mode change > advance > hold.
- Mode change (mode != mode_q):
  - mode_q=mode, pat=seed, bdir=up, cnt=0.
  - No tick, no wrap. en and step are ignored that cycle.
- Advance condition:
  - en=1 and cnt >= div_eff-1: cnt=0, then advance.
  - en=1 otherwise: cnt=cnt+1, no advance.
  - en=0: cnt holds. Each cycle with step=1 advances once; step is level-sampled, so each high cycle is one advance.
- Advance per mode:
  - 0, 3: pat=pat±1 modulo 2^LED_W. wrap=1 on all-ones→0 (up) or 0→all-ones (down).
  - 1: rotate left (dir=0) or right (dir=1) by one bit. wrap=1 when the new pat equals 1.
  - 2: shift toward MSB while bdir=up, toward LSB while down. On reaching bit LED_W-1, bdir=down. On reaching bit 0, bdir=up and wrap=1. The turnaround does not repeat the end LED.
- tick=1 exactly on cycles following an advance edge; else 0. Same for wrap.
- Arithmetic: cnt compare uses an unsigned DIV_W-bit comparison against div_eff=max(div,1).
- Lowering div below cnt+1 mid-count causes an advance on the next edge.

## Timing
- Cycle numbering: edge 1 is the first edge with rst=0.
- With en=1 from edge 1, constant div=N and cnt=0, advances occur at edges N, 2N, 3N, …; the tick period is N cycles. div=0 or 1 advances every edge.
- led, tick and wrap all change on the advance edge; zero added latency.
- Manual step: the advance occurs on the edge sampling step=1.
- Mode change: the new seed appears on led one edge after mode changes; first advance N edges later.
- Reset mid-operation: all state returns to reset values on that edge; no residual tick or wrap.
- Bounce cycle length: 2·(LED_W-1) advances (14 for LED_W=8; 2 for LED_W=2: 1,2,1,…).

## Test plan
- Reset with mode=0, dir=0, div=4, en=1 (LED_W=8) → led=0 after reset. led=1,2,3 at edges 4,8,12. tick high only on those cycles. wrap=0.
- Mode 0, div=1: run 256 advances → led 255→0 with a single wrap pulse. Switch dir=1 at led=0 → led=255 with a wrap pulse.
- Mode 2, div=1 → led 1,2,4,…,128,64,…,2,1,2. wrap pulses only on each return to 1, every 14 advances.
- Mode 3, div=1 → led 0,1,3,2,6,7,5,4,12. Mode 1, dir=1 → led 1,128,64. wrap pulses on each return to 1.
- div=10, en=1, cnt reaches 7, then div set to 3 → advance on the next edge, then every 3. With cnt at 5, switch mode 0→1 → led=1 next edge, no tick, next advance div edges later.
- en=0, step high for 3 cycles, then 1 pulse → exactly 4 advances and 4 tick pulses, cnt unchanged. Assert rst mid-run with mode=2 → led=1, tick=wrap=0 on that edge.
